floo_source_route_pop: RTL and testbench

FLOO_SOURCE_ROUTE_POP -- requirements
Module: floo_source_route_pop

---
 rtl/floo_pkg.sv | 12 +
 rtl/floo_route_skid.sv | 65 ++++++
 rtl/floo_source_route_pop.sv | 103 ++++++++++
 tb/tb_floo_source_route_pop.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/floo_pkg.sv
// Shared FlooNoC definitions.
// Only the routing-algorithm selector lives here; blocks keep their own
// derived widths and entry types local so the package stays stable.
package floo_pkg;

  typedef enum logic [1:0] {
    IdTable       = 2'd0,
    SourceRouting = 2'd1,
    XYRouting     = 2'd2
  } route_algo_e;

endpackage

// File: rtl/floo_route_skid.sv
// floo_route_skid: 2-entry FIFO, generic over the stored entry type.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   push, wdata   : enqueue request and entry (ignored when full)
//   ready         : not full (registered state only)
//   valid, rdata  : head entry present / head entry
//   pop           : dequeue request (ignored when empty)
module floo_route_skid #(
  parameter type entry_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push,
  input  entry_t wdata,
  output logic   ready,
  output logic   valid,
  input  logic   pop,
  output entry_t rdata
);
  import floo_pkg::*;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e state_q, state_d;
  logic   wr_ptr, rd_ptr;
  entry_t mem [2];
  logic   do_push, do_pop;

  assign ready   = (state_q != FULL);
  assign valid   = (state_q != EMPTY);
  assign rdata   = mem[rd_ptr];
  assign do_push = push && ready;
  assign do_pop  = pop && valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (do_push) state_d = ONE;
      ONE: begin
        if (do_push && !do_pop)      state_d = FULL;
        else if (!do_push && do_pop) state_d = EMPTY;
      end
      FULL:    if (do_pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Storage is reset too so the outputs read zero while in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/floo_source_route_pop.sv
// floo_source_route_pop: consumes the low PortIdxW bits of a source route
// to pick this hop's output port, and buffers {port, remaining route, data}
// in a 2-entry FIFO. Flits naming a port >= NumPorts are consumed and
// reported with a one-cycle drop_o pulse.
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   valid_i/ready_o        : upstream handshake; route_i, data_i in
//   valid_o/ready_i        : downstream handshake; port_o, route_o, data_o out
//   drop_o                 : illegal-port drop pulse
//   fwd_cnt_o, drop_cnt_o  : saturating statistics
// Build option: FLOO_SOURCE_ROUTE_STATS_EN enables the counters; otherwise
// they read zero and no counter flops exist.
module floo_source_route_pop #(
  parameter int unsigned NumPorts   = 5,
  parameter int unsigned RouteWidth = 20,
  parameter type         data_t     = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [RouteWidth-1:0]    route_i,
  input  data_t                    data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(NumPorts)-1:0] port_o,
  output logic [RouteWidth-1:0]    route_o,
  output data_t                    data_o,
  output logic                     drop_o,
  output logic [15:0]              fwd_cnt_o,
  output logic [15:0]              drop_cnt_o
);
  import floo_pkg::*;

  localparam int unsigned PortIdxW = $clog2(NumPorts);

  typedef struct packed {
    logic [PortIdxW-1:0]   port;
    logic [RouteWidth-1:0] route;
    data_t                 data;
  } entry_t;

  logic [PortIdxW-1:0] port_in;
  logic   illegal, accept, push, pop, drop_q;
  entry_t wentry, rentry;

  assign port_in = route_i[PortIdxW-1:0];
  // Zero-extend before comparing so power-of-two NumPorts never drops.
  assign illegal = (32'(port_in) >= NumPorts);
  assign accept  = valid_i && ready_o;
  assign push    = accept && !illegal;
  assign pop     = valid_o && ready_i;

  assign wentry.port  = port_in;
  assign wentry.route = route_i >> PortIdxW;
  assign wentry.data  = data_i;

  floo_route_skid #(.entry_t(entry_t)) i_skid (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push),
    .wdata (wentry),
    .ready (ready_o),
    .valid (valid_o),
    .pop   (pop),
    .rdata (rentry)
  );

  assign port_o  = rentry.port;
  assign route_o = rentry.route;
  assign data_o  = rentry.data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drop_q <= 1'b0;
    else         drop_q <= accept && illegal;
  end
  assign drop_o = drop_q;

`ifdef FLOO_SOURCE_ROUTE_STATS_EN
  logic [15:0] fwd_cnt_q, drop_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pop && fwd_cnt_q != 16'hFFFF) fwd_cnt_q <= fwd_cnt_q + 16'd1;
      if (accept && illegal && drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
  assign fwd_cnt_o  = fwd_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`else
  assign fwd_cnt_o  = '0;
  assign drop_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  data_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> $stable(data_o));
`endif

endmodule

// File: tb/tb_floo_source_route_pop.sv
module tb_floo_source_route_pop;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o, valid_o, ready_i, drop_o;
  logic [19:0] route_i, route_o;
  logic [7:0]  data_i, data_o;
  logic [2:0]  port_o;
  logic [15:0] fwd_cnt_o, drop_cnt_o;

  floo_source_route_pop #(.NumPorts(5), .RouteWidth(20), .data_t(logic [7:0])) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .route_i(route_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
    .port_o(port_o), .route_o(route_o), .data_o(data_o), .drop_o(drop_o),
    .fwd_cnt_o(fwd_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] route;
    logic [7:0]  data;
    logic [2:0]  exp_port;
    logic [19:0] exp_route;
    bit          exp_drop;
  } vec_t;

  typedef struct {
    logic [2:0]  port;
    logic [19:0] route;
    logic [7:0]  data;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_err = 0;
  int   n_pop = 0, n_drop = 0;
  bit   drop_due = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from updates.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("drop_o", {31'd0, drop_o}, {31'd0, drop_due});
      drop_due = 0;
      if (valid_o) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'd1, 32'd0);
        end else if (ready_i) begin
          exp_t e;
          e = q.pop_front();
          chk("port_o", {29'd0, port_o}, {29'd0, e.port});
          chk("route_o", {12'd0, route_o}, {12'd0, e.route});
          chk("data_o", {24'd0, data_o}, {24'd0, e.data});
          n_pop++;
        end
      end
    end
  end

  // Drive one flit; returns number of cycles it waited for acceptance.
  task automatic send(input vec_t v, output int waits);
    bit acc;
    exp_t e;
    valid_i = 1'b1; route_i = v.route; data_i = v.data;
    waits = 0;
    acc = 0;
    while (!acc && waits < 50) begin
      @(negedge clk); acc = ready_o;
      @(posedge clk); #1;
      waits++;
    end
    valid_i = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    else if (v.exp_drop) begin
      drop_due = 1; n_drop++;
    end else begin
      e.port = v.exp_port; e.route = v.exp_route; e.data = v.data;
      q.push_back(e);
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((q.size() != 0 || valid_o) && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", q.size(), 32'd0);
  endtask

  vec_t tbl[8];
  vec_t v;
  int   w;

  initial begin
    tbl[0] = '{20'h0001A, 8'h11, 3'd2, 20'h00003, 1'b0};
    tbl[1] = '{20'h00000, 8'h22, 3'd0, 20'h00000, 1'b0};
    tbl[2] = '{20'hFFFFC, 8'h33, 3'd4, 20'h1FFFF, 1'b0};
    tbl[3] = '{20'h00006, 8'h44, 3'd0, 20'h00000, 1'b1};
    tbl[4] = '{20'h00007, 8'h55, 3'd0, 20'h00000, 1'b1};
    tbl[5] = '{20'h00005, 8'h66, 3'd0, 20'h00000, 1'b1};
    tbl[6] = '{20'h12344, 8'h77, 3'd4, 20'h02468, 1'b0};
    tbl[7] = '{20'h80009, 8'h88, 3'd1, 20'h10001, 1'b0};

    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; route_i = '0; data_i = '0;
    #1;
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_ready_o", {31'd0, ready_o}, 32'd1);
    chk("rst_drop_o", {31'd0, drop_o}, 32'd0);
    chk("rst_fwd_cnt", {16'd0, fwd_cnt_o}, 32'd0);
    chk("rst_drop_cnt", {16'd0, drop_cnt_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1;

    // First-flit latency: visible on the cycle after acceptance.
    send(tbl[0], w);
    @(negedge clk);
    chk("lat_valid_o", {31'd0, valid_o}, 32'd1);
    chk("lat_port_o", {29'd0, port_o}, 32'd2);
    chk("lat_route_o", {12'd0, route_o}, 32'h00003);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      send(tbl[i], w);
      chk("tbl_no_wait", w, 32'd1);
    end
    wait_empty();
`ifdef FLOO_SOURCE_ROUTE_STATS_EN
    chk("drop_cnt", {16'd0, drop_cnt_o}, n_drop);
    chk("fwd_cnt", {16'd0, fwd_cnt_o}, n_pop);
`else
    chk("drop_cnt_off", {16'd0, drop_cnt_o}, 32'd0);
    chk("fwd_cnt_off", {16'd0, fwd_cnt_o}, 32'd0);
`endif

    // Three pushes into a stalled output: third waits, head holds flit 1.
    ready_i = 1'b0;
    send('{20'h00009, 8'hA1, 3'd1, 20'h00001, 1'b0}, w);
    send('{20'h00012, 8'hA2, 3'd2, 20'h00002, 1'b0}, w);
    chk("full_ready_o", {31'd0, ready_o}, 32'd0);
    fork
      send('{20'h0001B, 8'hA3, 3'd3, 20'h00003, 1'b0}, w);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("hold_data_o", {24'd0, data_o}, 32'hA1);
          chk("hold_ready_o", {31'd0, ready_o}, 32'd0);
        end
        @(posedge clk); #1 ready_i = 1'b1;
      end
    join
    chk("third_waited", {31'd0, w > 1}, 32'd1);
    wait_empty();

    // Streaming in state ONE: push and pop together, no bubble.
    for (int i = 0; i < 4; i++) begin
      v = '{20'h0000C + 20'(i) * 20'h8, 8'(8'hC0 + i), 3'd4, 20'h1 + 20'(i), 1'b0};
      send(v, w);
      chk("stream_no_wait", w, 32'd1);
    end
    @(negedge clk);
    chk("stream_valid_o", {31'd0, valid_o}, 32'd1);
    chk("stream_depth", q.size(), 32'd1);
    wait_empty();

    // Long forward run drives the forward counter to saturation.
    for (int i = 0; i < 70000; i++) begin
      send('{20'h00009, 8'(i), 3'd1, 20'h00001, 1'b0}, w);
      if (w != 1) chk("long_no_wait", w, 32'd1);
    end
    wait_empty();
`ifdef FLOO_SOURCE_ROUTE_STATS_EN
    chk("fwd_cnt_sat", {16'd0, fwd_cnt_o}, 32'h0000FFFF);
`else
    chk("fwd_cnt_off_long", {16'd0, fwd_cnt_o}, 32'd0);
`endif

    // Asynchronous reset while FULL: flits lost, no drop pulse.
    ready_i = 1'b0;
    send('{20'h00001, 8'hE1, 3'd1, 20'h00000, 1'b0}, w);
    send('{20'h00002, 8'hE2, 3'd2, 20'h00000, 1'b0}, w);
    chk("pre_rst_ready_o", {31'd0, ready_o}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("arst_ready_o", {31'd0, ready_o}, 32'd1);
    chk("arst_outs", {9'd0, port_o, route_o}, 32'd0);
    chk("arst_data_o", {24'd0, data_o}, 32'd0);
    q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("arst_drop_o", {31'd0, drop_o}, 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    chk("post_rst_drop_o", {31'd0, drop_o}, 32'd0);
    chk("post_rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("post_rst_fwd_cnt", {16'd0, fwd_cnt_o}, 32'd0);
    chk("post_rst_drop_cnt", {16'd0, drop_cnt_o}, 32'd0);

    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
